// File: rtl/match_list_reader_pkg.sv
// Shared sizes and FSM encoding for the match-list read-out path.
package match_list_reader_pkg;

  localparam int unsigned NUM_SLOTS = 10;
  localparam int unsigned POS_N     = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned COST_W    = 10;
  localparam int unsigned LIST_W    = 24;
  localparam int unsigned STORE_W   = NUM_SLOTS * LIST_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/match_list_reader_slicer.sv
// Combinational (slot, position) -> job lookup into the packed list store.
module match_entry_slicer
  import match_list_reader_pkg::*;
(
  input  logic [STORE_W-1:0] list,
  input  logic [3:0]         slot,
  input  logic [2:0]         pos,
  output logic [IDX_W-1:0]   job
);

  logic [LIST_W-1:0] word;

  // Position 0 sits in the top bits of each slot word, position 7 in the bottom.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot == 4'(i)) word = list[i*LIST_W +: LIST_W];
    end
    job = '0;
    for (int unsigned p = 0; p < POS_N; p++) begin
      if (pos == 3'(p)) job = word[LIST_W - IDX_W - p*IDX_W +: IDX_W];
    end
  end

endmodule

// File: rtl/match_list_reader.sv
// Snapshots the match-list store and streams each (list, position, job) element with valid/ready.
module match_list_reader
  import match_list_reader_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [STORE_W-1:0] Match_list,
  input  logic [3:0]         list_count,
  input  logic [COST_W-1:0]  MinCost,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_list_idx,
  output logic [2:0]         out_pos,
  output logic [IDX_W-1:0]   out_job,
  output logic               out_last_pos,
  output logic               out_last_list,
  output logic [COST_W-1:0]  out_cost,
  output logic               done
);

  state_t             state, state_nx;
  logic [STORE_W-1:0] list_r;
  logic [3:0]         cnt_r;
  logic [3:0]         slot_r;
  logic [2:0]         pos_r;
  logic [COST_W-1:0]  cost_r;
  logic [3:0]         cnt_clamp;
  logic               hs;
  logic               pos_end;
  logic               slot_end;
  logic [IDX_W-1:0]   job;

  assign cnt_clamp = (list_count > 4'(NUM_SLOTS)) ? 4'(NUM_SLOTS) : list_count;
  assign pos_end   = (pos_r == 3'(POS_N - 1));
  assign slot_end  = (slot_r == cnt_r - 4'd1);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    hs        = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = (cnt_clamp == 4'd0) ? S_DONE : S_EMIT;
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        hs        = out_ready;
        if (hs && pos_end && slot_end) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      list_r <= '0;
      cnt_r  <= '0;
      cost_r <= '0;
      slot_r <= '0;
      pos_r  <= '0;
    end else if (state == S_IDLE && start) begin
      list_r <= Match_list;
      cnt_r  <= cnt_clamp;
      cost_r <= MinCost;
      slot_r <= '0;
      pos_r  <= '0;
    end else if (hs) begin
      if (pos_end) begin
        pos_r  <= '0;
        slot_r <= slot_r + 4'd1;
      end else begin
        pos_r <= pos_r + 3'd1;
      end
    end
  end

  match_entry_slicer u_slicer (
    .list (list_r),
    .slot (slot_r),
    .pos  (pos_r),
    .job  (job)
  );

  // Element fields are forced to zero outside EMIT so idle/reset outputs read all-zero.
  assign out_list_idx  = out_valid ? slot_r : '0;
  assign out_pos       = out_valid ? pos_r  : '0;
  assign out_job       = out_valid ? job    : '0;
  assign out_last_pos  = out_valid && pos_end;
  assign out_last_list = out_valid && slot_end;
  assign out_cost      = busy ? cost_r : '0;

endmodule

// File: tb/tb_match_list_reader.sv
// Scoreboarded directed bench for the match-list read-out streamer.
module tb_match_list_reader;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [239:0] Match_list;
  logic [3:0]   list_count;
  logic [9:0]   MinCost;
  logic         busy, out_valid, out_ready;
  logic [3:0]   out_list_idx;
  logic [2:0]   out_pos;
  logic [2:0]   out_job;
  logic         out_last_pos, out_last_list;
  logic [9:0]   out_cost;
  logic         done;

  match_list_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .Match_list(Match_list),
    .list_count(list_count), .MinCost(MinCost), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_list_idx(out_list_idx),
    .out_pos(out_pos), .out_job(out_job), .out_last_pos(out_last_pos),
    .out_last_list(out_last_list), .out_cost(out_cost), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] idx;
    logic [2:0] pos;
    logic [2:0] job;
    logic       lp;
    logic       ll;
    logic [9:0] cost;
  } elem_t;

  elem_t sb[$];
  int errors = 0;
  int checks = 0;
  int hs_cnt, done_cnt, last_t;
  logic [3:0] last_idx;
  logic [239:0] ml;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, out_valid, out_list_idx, out_pos, out_job, out_last_pos, out_last_list, out_cost};
  endfunction

  function automatic logic [239:0] rand_ml();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[239:0];
  endfunction

  // Expected stream: octal digit p (most significant first) of each slot word.
  task automatic push_expected(input logic [239:0] m, input logic [3:0] cnt, input logic [9:0] cost);
    int n;
    logic [23:0] w;
    elem_t e;
    n = (cnt > 4'd10) ? 10 : int'(cnt);
    for (int s = 0; s < n; s++) begin
      w = m[s*24 +: 24];
      for (int p = 0; p < 8; p++) begin
        e.idx  = 4'(s);
        e.pos  = 3'(p);
        e.job  = 3'(w >> (3*(7-p)));
        e.lp   = (p == 7);
        e.ll   = (s == n-1);
        e.cost = cost;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_start(input logic [239:0] m, input logic [3:0] cnt, input logic [9:0] cost);
    Match_list = m;
    list_count = cnt;
    MinCost    = cost;
    start      = 1'b1;
    push_expected(m, cnt, cost);
    @(negedge CLK);
    start = 1'b0;
    check("busy_latency", busy, 1);
    check("valid_latency", out_valid, (cnt != 4'd0));
  endtask

  // mode 0: ready held high; 1: ready toggles 1,0; 2: ready high plus start/input disturbance.
  task automatic stream(input int mode, input int abort_at, input int budget);
    logic [31:0] snap;
    logic pend;
    int t;
    elem_t e;
    pend = 1'b0; t = 0; hs_cnt = 0; done_cnt = 0;
    forever begin
      if (pend) begin
        check("stall_hold", outs(), snap);
        pend = 1'b0;
      end
      if (done) done_cnt++;
      if (done_cnt > 0 && sb.size() == 0) break;
      if (t >= budget) begin
        check("timeout_pending", sb.size(), 0);
        check("timeout_done", done_cnt, 1);
        break;
      end
      if (abort_at >= 0 && hs_cnt == abort_at && out_valid) begin
        RST = 1'b1;
        break;
      end
      out_ready = (mode == 1) ? (t % 2 == 0) : 1'b1;
      start     = (mode == 2) && (t == 3);
      if (mode == 2 && t == 3) begin
        Match_list = rand_ml();
        MinCost    = 10'h3ff;
        list_count = 4'd10;
      end
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) check("extra_elem", sb.size(), 1);
          else begin
            e = sb.pop_front();
            check("list_idx",  out_list_idx,  e.idx);
            check("pos",       out_pos,       e.pos);
            check("job",       out_job,       e.job);
            check("last_pos",  out_last_pos,  e.lp);
            check("last_list", out_last_list, e.ll);
            check("cost",      out_cost,      e.cost);
          end
          hs_cnt++;
          last_idx = out_list_idx;
        end else begin
          snap = outs();
          pend = 1'b1;
        end
      end
      @(negedge CLK);
      t++;
    end
    last_t = t;
  endtask

  task automatic post_checks();
    @(negedge CLK);
    start = 1'b0;
    check("done_single", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_cost", out_cost, 0);
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; out_ready = 1'b0;
    Match_list = '0; list_count = '0; MinCost = '0;
    repeat (3) @(negedge CLK);
    check("reset_outs", outs(), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Single list, octal 01234567 -> jobs 0..7 back to back.
    ml = '0;
    ml[23:0] = 24'o01234567;
    do_start(ml, 4'd1, 10'd37);
    stream(0, -1, 100);
    check("hs_count1", hs_cnt, 8);
    check("throughput1", last_t, 8);
    post_checks();

    // Three lists with ready toggling.
    do_start(rand_ml(), 4'd3, 10'd100);
    stream(1, -1, 200);
    check("hs_count3", hs_cnt, 24);
    post_checks();

    // Empty read.
    do_start(rand_ml(), 4'd0, 10'd5);
    check("empty_done", done, 1);
    stream(0, -1, 10);
    check("hs_count0", hs_cnt, 0);
    post_checks();

    // Count above capacity clamps to 10 lists.
    do_start(rand_ml(), 4'd12, 10'd512);
    stream(0, -1, 200);
    check("hs_count12", hs_cnt, 80);
    check("last_idx12", last_idx, 9);
    post_checks();

    // Reset at slot1/pos5 aborts immediately without done.
    do_start(rand_ml(), 4'd3, 10'd77);
    stream(0, 13, 100);
    check("abort_idx", out_list_idx, 1);
    check("abort_pos", out_pos, 5);
    @(negedge CLK);
    check("abort_outs", outs(), 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("abort_no_done", done, 0);
    do_start(rand_ml(), 4'd2, 10'd9);
    stream(0, -1, 100);
    check("hs_restart", hs_cnt, 16);
    post_checks();

    // Start re-pulsed in EMIT and on DONE; inputs change after capture.
    do_start(rand_ml(), 4'd4, 10'd37);
    stream(2, -1, 200);
    check("hs_repulse", hs_cnt, 32);
    start = 1'b1;
    post_checks();
    @(negedge CLK);
    check("repulse_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
